level_queue: RTL and testbench

LEVEL_QUEUE -- requirements
Module: level_queue

---
 rtl/queue_pkg.sv | 26 ++
 rtl/level_queue_wrap_counter.sv | 38 +++
 rtl/level_queue.sv | 126 ++++++++++++
 tb/tb_level_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared helpers for the queue family: width derivation and handshake/status bundles.
// Pure declarations; no latency or backpressure of its own.
package queue_pkg;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Depth >= 2 always yields at least one pointer bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } q_flags_t;

    typedef struct packed {
        logic wr;
        logic rd;
    } q_xfer_t;

endpackage

// File: rtl/level_queue_wrap_counter.sv
// Modulo-N pointer counter; counts 0..Modulus-1 and wraps, with synchronous clear.
// Latency: new value one edge after en/clr; no backpressure (clr beats en).
module wrap_counter
    import queue_pkg::*;
#(
    parameter int Modulus = 6,
    localparam int Width  = ptr_width(Modulus)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] cnt
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == Width'(Modulus - 1)) ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/level_queue.sv
// First-word-fall-through queue with registered occupancy and threshold flags.
// Latency: write visible on dOUT one edge later; backpressure via dInREQ=!full. LEVEL_QUEUE_ERR_FLAGS_EN adds sticky Overflow/Underflow.
module level_queue
    import queue_pkg::*;
#(
    parameter int BitWidth    = 32,
    parameter int BufferDepth = 6,
    localparam int LevelWidth = level_width(BufferDepth),
    localparam int PtrWidth   = ptr_width(BufferDepth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    output logic                  dInREQ,
    input  logic                  dInACK,
    input  logic [BitWidth-1:0]   dIN,
    output logic                  dOutACK,
    input  logic                  dOutREQ,
    output logic [BitWidth-1:0]   dOUT,
    output logic [LevelWidth-1:0] Level,
    input  logic [LevelWidth-1:0] AlmostFullThr,
    input  logic [LevelWidth-1:0] AlmostEmptyThr,
`ifdef LEVEL_QUEUE_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  Overflow,
    output logic                  Underflow,
`endif
    output logic                  BufferFull,
    output logic                  BufferEmpty,
    output logic                  AlmostFull,
    output logic                  AlmostEmpty
);

    logic [BitWidth-1:0]   mem [BufferDepth];
    logic [LevelWidth-1:0] level_q;
    logic [LevelWidth-1:0] level_d;
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    q_flags_t              status;
    q_xfer_t               xfer;

    // Status depends only on the registered level, never on this cycle's handshakes.
    assign status.full         = (level_q == LevelWidth'(BufferDepth));
    assign status.empty        = (level_q == '0);
    assign status.almost_full  = (level_q >= AlmostFullThr);
    assign status.almost_empty = (level_q <= AlmostEmptyThr);

    assign xfer.wr = dInACK  && !status.full  && !flush;
    assign xfer.rd = dOutREQ && !status.empty && !flush;

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (xfer.wr && !xfer.rd) begin
            level_d = level_q + LevelWidth'(1);
        end else if (xfer.rd && !xfer.wr) begin
            level_d = level_q - LevelWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    wrap_counter #(.Modulus(BufferDepth)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (xfer.wr),
        .cnt   (wr_ptr)
    );

    wrap_counter #(.Modulus(BufferDepth)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (xfer.rd),
        .cnt   (rd_ptr)
    );

    // Storage is deliberately unreset; stale words are masked by the level.
    always_ff @(posedge clk) begin
        if (xfer.wr) begin
            mem[wr_ptr] <= dIN;
        end
    end

    assign dOUT        = mem[rd_ptr];
    assign Level       = level_q;
    assign dInREQ      = !status.full;
    assign dOutACK     = !status.empty;
    assign BufferFull  = status.full;
    assign BufferEmpty = status.empty;
    assign AlmostFull  = status.almost_full;
    assign AlmostEmpty = status.almost_empty;

`ifdef LEVEL_QUEUE_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Set wins over a same-cycle clear.
    always_comb begin
        overflow_d  = (dInACK && status.full)   || (overflow_q  && !err_clr);
        underflow_d = (dOutREQ && status.empty) || (underflow_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
`endif

endmodule

// File: tb/tb_level_queue.sv
// Directed bench for level_queue (BufferDepth=6): driver feeds a data scoreboard, a negedge monitor checks dOUT.
module tb_level_queue;

    localparam int BW = 32;
    localparam int BD = 6;
    localparam int LW = $clog2(BD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          dInREQ;
    logic          dInACK = 1'b0;
    logic [BW-1:0] dIN = '0;
    logic          dOutACK;
    logic          dOutREQ = 1'b0;
    logic [BW-1:0] dOUT;
    logic [LW-1:0] Level;
    logic [LW-1:0] AlmostFullThr  = LW'(5);
    logic [LW-1:0] AlmostEmptyThr = LW'(1);
    logic          BufferFull, BufferEmpty, AlmostFull, AlmostEmpty;
`ifdef LEVEL_QUEUE_ERR_FLAGS_EN
    logic          err_clr = 1'b0;
    logic          Overflow, Underflow;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    level_queue #(.BitWidth(BW), .BufferDepth(BD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .dInREQ         (dInREQ),
        .dInACK         (dInACK),
        .dIN            (dIN),
        .dOutACK        (dOutACK),
        .dOutREQ        (dOutREQ),
        .dOUT           (dOUT),
        .Level          (Level),
        .AlmostFullThr  (AlmostFullThr),
        .AlmostEmptyThr (AlmostEmptyThr),
`ifdef LEVEL_QUEUE_ERR_FLAGS_EN
        .err_clr        (err_clr),
        .Overflow       (Overflow),
        .Underflow      (Underflow),
`endif
        .BufferFull     (BufferFull),
        .BufferEmpty    (BufferEmpty),
        .AlmostFull     (AlmostFull),
        .AlmostEmpty    (AlmostEmpty)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic cycle(input logic wr, input logic [BW-1:0] d, input logic rd, input logic fl);
        dInACK  = wr;
        dIN     = d;
        dOutREQ = rd;
        flush   = fl;
        if (fl) exp_q.delete();
        else if (wr && dInREQ) exp_q.push_back(d);
        @(posedge clk);
        #1;
        dInACK  = 1'b0;
        dOutREQ = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic check_flags(input string tag, input int lvl);
        check({tag, " Level"},       BW'(Level),       BW'(lvl));
        check({tag, " BufferFull"},  BW'(BufferFull),  BW'(lvl == BD));
        check({tag, " BufferEmpty"}, BW'(BufferEmpty), BW'(lvl == 0));
        check({tag, " dInREQ"},      BW'(dInREQ),      BW'(lvl != BD));
        check({tag, " dOutACK"},     BW'(dOutACK),     BW'(lvl != 0));
        check({tag, " AlmostFull"},  BW'(AlmostFull),  BW'(lvl >= 5));
        check({tag, " AlmostEmpty"}, BW'(AlmostEmpty), BW'(lvl <= 1));
    endtask

    // Monitor: every accepted read must match the oldest outstanding write.
    always @(negedge clk) begin
        if (rst_n && dOutREQ && dOutACK && !flush) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL monitor: unexpected dOUT 0x%0h with empty scoreboard", dOUT);
            end else begin
                check("monitor dOUT", dOUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_flags("reset", 0);

        // Fill 0x11..0x16 with threshold flags checked at every level.
        for (int i = 1; i <= BD; i++) begin
            cycle(1'b1, BW'(32'h10 + i), 1'b0, 1'b0);
            check_flags($sformatf("fill%0d", i), i);
        end
        cycle(1'b1, 32'h99, 1'b0, 1'b0);
        check_flags("overfill", BD);
`ifdef LEVEL_QUEUE_ERR_FLAGS_EN
        check("Overflow", BW'(Overflow), 1);
`endif

        for (int i = 1; i <= BD; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("drained", 0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("underread", 0);
`ifdef LEVEL_QUEUE_ERR_FLAGS_EN
        check("Underflow", BW'(Underflow), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("Overflow cleared", BW'(Overflow), 0);
        check("Underflow cleared", BW'(Underflow), 0);
`endif

        // Pointers have wrapped; write/read pairs must still return the right data.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, BW'(32'h21 + i), 1'b0, 1'b0);
            check("wrap dOUT direct", dOUT, BW'(32'h21 + i));
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        check_flags("wrap done", 0);

        // Steady simultaneous read+write at Level 3.
        for (int i = 0; i < 3; i++) cycle(1'b1, BW'(32'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, BW'(32'h40 + i), 1'b1, 1'b0);
            check($sformatf("rw level %0d", i), BW'(Level), 3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("rw drained", 0);

        // Flush at Level 4 beats a same-cycle write.
        for (int i = 0; i < 4; i++) cycle(1'b1, BW'(32'h50 + i), 1'b0, 1'b0);
        check("pre-flush Level", BW'(Level), 4);
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b1);
        check_flags("flush", 0);
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        check("post-flush dOUT", dOUT, 32'h55);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst at Level 4.
        for (int i = 0; i < 4; i++) cycle(1'b1, BW'(32'h60 + i), 1'b0, 1'b0);
        dInACK = 1'b1;
        dIN    = 32'h64;
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("async reset", 0);
        dInACK = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_flags("post reset", 0);
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        cycle(1'b1, 32'h78, 1'b0, 1'b0);
        check("resume Level", BW'(Level), 2);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("final", 0);
        check("scoreboard residue", BW'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
